// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared types and helpers for the iterative multiply/divide sequencer
//
// Contents:
//   XLEN         default operand/result width
//   mdu_op_e     RV32M funct3 encodings
//   mdu_state_e  sequencer states
//   op_signed_a / op_signed_b  operand signedness per op
//   div_special  result for divide-by-zero and signed overflow
package mdu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_e;

  // rs1 is signed for MUL, MULH, MULHSU, DIV, REM
  function automatic logic op_signed_a(input logic [2:0] op);
    return (~op[2] & (op[1:0] != 2'b11)) | (op[2] & ~op[0]);
  endfunction

  // rs2 is signed for MUL, MULH, DIV, REM
  function automatic logic op_signed_b(input logic [2:0] op);
    return (~op[2] & ~op[1]) | (op[2] & ~op[0]);
  endfunction

  // Divide by zero: quotient all-ones, remainder = dividend.
  // Signed overflow (MIN / -1): quotient = dividend (MIN), remainder 0.
  function automatic logic [XLEN-1:0] div_special(input logic is_rem,
                                                  input logic [XLEN-1:0] a,
                                                  input logic is_zero);
    if (is_zero) return is_rem ? a : {XLEN{1'b1}};
    else         return is_rem ? {XLEN{1'b0}} : a;
  endfunction

endpackage

// File: rtl/mdu_divstep.sv
// rtl/mdu_divstep.sv - one combinational restoring-division iteration
//
// Ports:
//   rem, quot, divisor    current partial remainder, quotient/dividend shift register, divisor
//   rem_next, quot_next   values after shifting {rem,quot} left and trial-subtracting
module mdu_divstep
  import mdu_pkg::*;
(
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quot,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quot_next
);

  logic [XLEN:0] trial;
  logic          ge;

  // rem < divisor always holds, so the shifted trial value needs one extra bit;
  // when it is >= divisor the difference fits back into XLEN bits.
  assign trial     = {rem, quot[XLEN-1]};
  assign ge        = (trial >= {1'b0, divisor});
  assign rem_next  = ge ? (trial[XLEN-1:0] - divisor) : trial[XLEN-1:0];
  assign quot_next = {quot[XLEN-2:0], ge};

endmodule

// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - iterative RV32M multiply/divide sequencer for the EX stage
//
// Ports:
//   clk, reset         clock; asynchronous active-high reset
//   MdStartE, MdOpE    start request and funct3 of the M op
//   SrcAE, SrcBE       forwarded rs1/rs2 operands
//   KillE              abort the in-flight op
//   StallE             hold F/D/E, bubble EX/MEM
//   MdDoneE, MdResultE result valid strobe and registered result
//
// Build option MDU_FASTPATH_EN: divide-by-zero and signed overflow skip the
// iterations and finish after a single stall cycle.
module mdu_seq
  import mdu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            MdStartE,
  input  logic [2:0]      MdOpE,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  input  logic            KillE,
  output logic            StallE,
  output logic            MdDoneE,
  output logic [XLEN-1:0] MdResultE
);

  localparam int CW = $clog2(XLEN);

  mdu_state_e      state, state_n;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] hi, lo, opb, a_raw;
  logic [1:0]      op;
  logic            sign_a, sign_b, div_zero, div_ovf;

  // Operand preparation in IDLE
  logic            in_sa, in_sb, in_zero, in_ovf, fast;
  logic [XLEN-1:0] abs_a, abs_b, fast_res;

  assign in_sa    = op_signed_a(MdOpE) & SrcAE[XLEN-1];
  assign in_sb    = op_signed_b(MdOpE) & SrcBE[XLEN-1];
  assign abs_a    = in_sa ? -SrcAE : SrcAE;
  assign abs_b    = in_sb ? -SrcBE : SrcBE;
  assign in_zero  = (SrcBE == '0);
  assign in_ovf   = op_signed_b(MdOpE) & MdOpE[2] &
                    (SrcAE == {1'b1, {(XLEN-1){1'b0}}}) & (&SrcBE);
  assign fast_res = div_special(MdOpE[1], SrcAE, in_zero);
`ifdef MDU_FASTPATH_EN
  assign fast     = MdOpE[2] & (in_zero | in_ovf);
`else
  assign fast     = 1'b0;
`endif

  // Multiply iteration: {hi,lo} product register, lo starts as the multiplier
  logic [XLEN:0]   mul_sum;
  logic [XLEN-1:0] mul_hi_n, mul_lo_n;
  assign mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
  assign mul_hi_n = mul_sum[XLEN:1];
  assign mul_lo_n = {mul_sum[0], lo[XLEN-1:1]};

  // Divide iteration: hi is the partial remainder, lo the dividend/quotient
  logic [XLEN-1:0] div_rem_n, div_quot_n;
  mdu_divstep u_divstep (
    .rem       (hi),
    .quot      (lo),
    .divisor   (opb),
    .rem_next  (div_rem_n),
    .quot_next (div_quot_n)
  );

  // Final results are formed from the last iteration's next values so that
  // MdResultE is already registered during the DONE cycle.
  logic [2*XLEN-1:0] prod, prod_c;
  logic [XLEN-1:0]   mul_res, quot_c, rem_c, div_res;
  logic              last;

  assign last    = (cnt == '0);
  assign prod    = {mul_hi_n, mul_lo_n};
  assign prod_c  = (sign_a ^ sign_b) ? -prod : prod;
  assign mul_res = (op == 2'b00) ? prod_c[XLEN-1:0] : prod_c[2*XLEN-1:XLEN];
  assign quot_c  = (sign_a ^ sign_b) ? -div_quot_n : div_quot_n;
  assign rem_c   = sign_a ? -div_rem_n : div_rem_n;
  assign div_res = (div_zero | div_ovf) ? div_special(op[1], a_raw, div_zero)
                                        : (op[1] ? rem_c : quot_c);

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (MdStartE) state_n = fast ? ST_DONE : (MdOpE[2] ? ST_DIV : ST_MUL);
      ST_MUL:  if (last) state_n = ST_DONE;
      ST_DIV:  if (last) state_n = ST_DONE;
      default: state_n = ST_IDLE;
    endcase
    if (KillE) state_n = ST_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      hi        <= '0;
      lo        <= '0;
      opb       <= '0;
      a_raw     <= '0;
      op        <= '0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      div_zero  <= 1'b0;
      div_ovf   <= 1'b0;
      MdResultE <= '0;
    end else begin
      state <= state_n;
      if (!KillE) begin
        case (state)
          ST_IDLE: if (MdStartE) begin
            cnt      <= CW'(XLEN - 1);
            hi       <= '0;
            lo       <= MdOpE[2] ? abs_a : abs_b;
            opb      <= MdOpE[2] ? abs_b : abs_a;
            a_raw    <= SrcAE;
            op       <= MdOpE[1:0];
            sign_a   <= in_sa;
            sign_b   <= in_sb;
            div_zero <= MdOpE[2] & in_zero;
            div_ovf  <= in_ovf;
            if (fast) MdResultE <= fast_res;
          end
          ST_MUL: begin
            hi  <= mul_hi_n;
            lo  <= mul_lo_n;
            cnt <= cnt - 1'b1;
            if (last) MdResultE <= mul_res;
          end
          ST_DIV: begin
            hi  <= div_rem_n;
            lo  <= div_quot_n;
            cnt <= cnt - 1'b1;
            if (last) MdResultE <= div_res;
          end
          default: ;
        endcase
      end
    end
  end

  assign StallE  = (((state == ST_IDLE) & MdStartE) | (state == ST_MUL) |
                    (state == ST_DIV)) & ~KillE;
  assign MdDoneE = (state == ST_DONE) & ~KillE;

endmodule

// File: tb/tb_mdu_seq.sv
// tb/tb_mdu_seq.sv - directed self-checking bench for mdu_seq
module tb_mdu_seq;

  localparam int SPC =
`ifdef MDU_FASTPATH_EN
    1;
`else
    33;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MdStartE = 1'b0;
  logic [2:0]  MdOpE = 3'b000;
  logic [31:0] SrcAE = '0;
  logic [31:0] SrcBE = '0;
  logic        KillE = 1'b0;
  logic        StallE, MdDoneE;
  logic [31:0] MdResultE;

  int n_cmp = 0;
  int n_bad = 0;

  mdu_seq dut (
    .clk       (clk),
    .reset     (reset),
    .MdStartE  (MdStartE),
    .MdOpE     (MdOpE),
    .SrcAE     (SrcAE),
    .SrcBE     (SrcBE),
    .KillE     (KillE),
    .StallE    (StallE),
    .MdDoneE   (MdDoneE),
    .MdResultE (MdResultE)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op, count stall cycles, then check the DONE cycle.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_stalls);
    int  stalls;
    bit  done;
    @(negedge clk);
    MdOpE = op; SrcAE = a; SrcBE = b; MdStartE = 1'b1;
    #1;
    check({tag, "/start_stall"}, {31'd0, StallE}, 32'd1);
    @(posedge clk);
    #1 MdStartE = 1'b0;
    stalls = 1;
    done   = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (StallE) stalls++;
      else        done = 1'b1;
    end
    check({tag, "/stalls"}, 32'(stalls), 32'(exp_stalls));
    check({tag, "/done"}, {31'd0, MdDoneE}, 32'd1);
    check({tag, "/result"}, MdResultE, exp);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst/stall", {31'd0, StallE}, 32'd0);
    check("rst/done", {31'd0, MdDoneE}, 32'd0);
    check("rst/result", MdResultE, 32'd0);
    reset = 1'b0;

    run_op("mul_7x-3",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    run_op("mulh_min2",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33);
    run_op("mulhu_max2",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run_op("mulhsu_m1",   3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
    run_op("div_-7_2",    3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
    run_op("rem_-7_2",    3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
    run_op("divu_100_7",  3'b101, 32'd100,      32'd7,        32'd14,       33);
    run_op("remu_100_7",  3'b111, 32'd100,      32'd7,        32'd2,        33);
    run_op("divu_by0",    3'b101, 32'h1234,     32'd0,        32'hFFFFFFFF, SPC);
    run_op("remu_by0",    3'b111, 32'h1234,     32'd0,        32'h1234,     SPC);
    run_op("div_ovf",     3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, SPC);
    run_op("rem_ovf",     3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        SPC);
    run_op("div_-5_by0",  3'b100, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, SPC);
    run_op("rem_-5_by0",  3'b110, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, SPC);

    // Kill a multiply partway through its iterations
    @(negedge clk);
    MdOpE = 3'b000; SrcAE = 32'h12345678; SrcBE = 32'd9; MdStartE = 1'b1;
    @(posedge clk);
    #1 MdStartE = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    KillE = 1'b1;
    #1;
    check("kill/stall_same", {31'd0, StallE}, 32'd0);
    check("kill/done_same", {31'd0, MdDoneE}, 32'd0);
    @(posedge clk);
    #1 KillE = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("kill/no_stall", {31'd0, StallE}, 32'd0);
      check("kill/no_done", {31'd0, MdDoneE}, 32'd0);
    end
    check("kill/result_kept", MdResultE, 32'hFFFFFFFB);
    run_op("mul_3x5", 3'b000, 32'd3, 32'd5, 32'd15, 33);

    // Reset in the middle of a divide
    @(negedge clk);
    MdOpE = 3'b101; SrcAE = 32'd1000; SrcBE = 32'd3; MdStartE = 1'b1;
    @(posedge clk);
    #1 MdStartE = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst/stall", {31'd0, StallE}, 32'd0);
    check("midrst/done", {31'd0, MdDoneE}, 32'd0);
    check("midrst/result", MdResultE, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op("divu_after_rst", 3'b101, 32'd100, 32'd7, 32'd14, 33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mdu_seq.md
# mdu_seq

Iterative multiply/divide sequencer for the execute stage of the 5-stage RV32 pipeline. Takes RV32M operations (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) issued into EX, runs a radix-2 shift-add multiply or a restoring divide over multiple cycles, and asserts a stall so the hazard unit holds F/D/E and bubbles EX/MEM until the result is ready. Its result feeds the EX result mux alongside the ALU result.

## Interface
- XLEN, 32, operand/result width; iteration counter is $clog2(XLEN) bits
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high; returns block to IDLE
- MdStartE  input  1  EX holds a valid M-extension instruction
- MdOpE  input  3  funct3 of the op (000 MUL … 111 REMU)
- SrcAE  input  XLEN  rs1 operand (post-forwarding)
- SrcBE  input  XLEN  rs2 operand (post-forwarding)
- KillE  input  1  abort the in-flight op (EX flush)
- StallE  output  1  hold F/D/E and bubble EX/MEM this cycle
- MdDoneE  output  1  MdResultE valid; EX instruction may advance this cycle
- MdResultE  output  XLEN  final result

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE: if MdStartE & ~KillE, latch |SrcAE|, |SrcBE|, sign flags, op; counter ← XLEN-1; go to MUL (op[2]=0) or DIV (op[2]=1). Otherwise stay.
- Operand signedness: MUL/MULH/DIV/REM both signed; MULHSU A signed, B unsigned; MULHU/DIVU/REMU unsigned.
- MUL: 2·XLEN product register {hi,lo}, lo initialised to multiplier; per cycle, if lo[0] add multiplicand to hi (XLEN+1-bit sum), shift right 1.
- DIV: restoring; per cycle shift {rem,quot} left 1, trial-subtract divisor from rem, keep if non-negative and set quot[0].
- Counter decrements each iteration cycle; at counter==0 go to DONE.
- DONE: apply sign correction (negate product if signs differ; quotient negated if signA^signB, remainder takes signA) and register into MdResultE; MUL → low half, MULH/MULHSU/MULHU → high half. MdDoneE=1. Next state IDLE unconditionally; MdStartE ignored in DONE.
- Special div cases: divisor 0 → quotient all-ones, remainder = SrcAE; signed DIV/REM of 0x80000000 by -1 → quotient 0x80000000, remainder 0. Values identical with or without fast path.
- StallE = ((IDLE & MdStartE) | MUL | DIV) & ~KillE. Low in DONE.
- KillE in any state: next state IDLE, MdDoneE not asserted, MdResultE retains prior value.
- MdStartE/operands ignored while MUL/DIV (held by stall upstream).

## Timing
- Normal op: start cycle + XLEN iteration cycles = XLEN+1 stall cycles (33), then one DONE cycle with MdDoneE=1, StallE=0.
- Fast path (when enabled): start cycle (StallE=1) → DONE next cycle; 1 stall cycle.
- StallE combinational from MdStartE/KillE/state; MdResultE and MdDoneE registered/state-decoded.
- Reset values: state IDLE, counter 0, MdResultE 0, MdDoneE 0, StallE 0 (with MdStartE=0).
- Reset mid-operation: immediate IDLE, partial result discarded, MdResultE 0.
- Back-to-back M ops: second op's start cycle is the cycle after DONE.

## Configuration
- MDU_FASTPATH_EN defined: divide-by-zero and signed overflow detected in IDLE, bypass DIV, reach DONE after 1 stall cycle.
- Undefined: these cases iterate the full XLEN cycles; DONE overrides result with the same special values.

## Structure
- Package mdu_pkg: XLEN default constant, mdu_op_e enum (funct3 encodings), mdu_state_e enum (IDLE/MUL/DIV/DONE).
- Sub-module mdu_divstep: combinational single restoring-division iteration (rem, quot, divisor in → rem, quot out); instantiated once.

## Test plan
- MUL 7 × -3 → StallE high 33 cycles, then MdDoneE=1, MdResultE=0xFFFFFFEB.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU -1 × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV -7 / 2 → 0xFFFFFFFD; REM -7 / 2 → 0xFFFFFFFF; DIVU 100 / 7 → 14, REMU → 2.
- DIVU 0x1234 / 0 → 0xFFFFFFFF, REMU → 0x1234; DIV 0x80000000 / -1 → 0x80000000, REM → 0; stall 1 cycle with MDU_FASTPATH_EN, 33 without.
- KillE at iteration 10 → StallE low same cycle, IDLE next cycle, no MdDoneE; following MUL 3×5 → 15.
- reset asserted mid-DIV → StallE, MdDoneE, MdResultE all 0 immediately; next op completes normally.
